// File: rtl/controlador_busca_pixels_pkg.sv
// Shared types and defaults for the frame-fetch controller: FSM encoding,
// default frame/FIFO geometry, RAM address width and the row-offset multiplier.
package controlador_busca_pixels_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    BUSCANDO = 2'd1,
    DRENANDO = 2'd2
  } estado_t;

  localparam int LARGURA_PADRAO      = 320;
  localparam int ALTURA_PADRAO       = 240;
  localparam int PROFUNDIDADE_PADRAO = 512;
  localparam int LIMIAR_PADRAO       = 480;
  localparam int LARGURA_END         = 17;

  // Row offset y*largura; 320 = 256 + 64 keeps it to two shifts and an adder.
  function automatic logic [LARGURA_END-1:0] vezes_largura(input logic [LARGURA_END-1:0] y,
                                                           input int largura);
    if (largura == 320) return (y << 8) + (y << 6);
    else return y * LARGURA_END'(largura);
  endfunction

endpackage

// File: rtl/gerador_endereco_zoom.sv
// Combinational pixel-to-RAM-address mapper. With ZOOM_2X_EN defined the
// zoom input selects a centred 2x window; otherwise only 1x mapping exists.
module gerador_endereco_zoom
  import controlador_busca_pixels_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO,
  parameter int ALTURA  = ALTURA_PADRAO
) (
  input  logic [$clog2(LARGURA)-1:0] ox,
  input  logic [$clog2(ALTURA)-1:0]  oy,
  input  logic                       zoom,
  output logic [LARGURA_END-1:0]     endereco
);

  logic [LARGURA_END-1:0] x_ef;
  logic [LARGURA_END-1:0] y_ef;

`ifdef ZOOM_2X_EN
  // Each source pixel is repeated twice in x and y, window centred in the frame.
  always_comb begin
    if (zoom) begin
      x_ef = LARGURA_END'(LARGURA / 4) + LARGURA_END'(ox >> 1);
      y_ef = LARGURA_END'(ALTURA / 4) + LARGURA_END'(oy >> 1);
    end else begin
      x_ef = LARGURA_END'(ox);
      y_ef = LARGURA_END'(oy);
    end
  end
`else
  logic zoom_unused;
  assign zoom_unused = zoom;
  assign x_ef = LARGURA_END'(ox);
  assign y_ef = LARGURA_END'(oy);
`endif

  assign endereco = vezes_largura(y_ef, LARGURA) + x_ef;

endmodule

// File: rtl/controlador_busca_pixels.sv
// Fetches one frame from pixel RAM into the display FIFO per iniciar pulse.
// Optional centred 2x zoom is built only when ZOOM_2X_EN is defined.
module controlador_busca_pixels
  import controlador_busca_pixels_pkg::*;
#(
  parameter int LARGURA      = LARGURA_PADRAO,
  parameter int ALTURA       = ALTURA_PADRAO,
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter int LIMIAR       = LIMIAR_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        fator_zoom,
  input  logic [9:0]  fila_nivel,
  input  logic [7:0]  dados_ram,
  output logic [16:0] endereco_ram,
  output logic        escrita_fila,
  output logic [7:0]  dados_fila,
  output logic        leitura_liberada,
  output logic        ocupado,
  output logic        fim_quadro,
  output logic [1:0]  estado
);

  localparam int OX_W = $clog2(LARGURA);
  localparam int OY_W = $clog2(ALTURA);
  localparam logic [OX_W-1:0]        OX_ULT     = OX_W'(LARGURA - 1);
  localparam logic [OY_W-1:0]        OY_ULT     = OY_W'(ALTURA - 1);
  localparam logic [9:0]             NIVEL_MAX  = 10'(PROFUNDIDADE - 3);
  localparam logic [LARGURA_END-1:0] LIMIAR_ULT = LARGURA_END'(LIMIAR - 1);

  estado_t                estado_atual;
  logic [OX_W-1:0]        ox;
  logic [OY_W-1:0]        oy;
  logic [LARGURA_END-1:0] endereco_reg;
  logic [LARGURA_END-1:0] endereco_atual;
  logic [LARGURA_END-1:0] contagem;
  logic                   zoom_efetivo;
  logic                   emitir;

  // Issue/write handshake: a read is issued in cycle t iff BUSCANDO and the FIFO
  // has room for the in-flight byte plus usedw lag; the address is valid in t,
  // the RAM answers in t+1 and escrita_fila is high exactly then. No issue means
  // the address is held and no write follows.
  assign emitir       = (estado_atual == BUSCANDO) && (fila_nivel <= NIVEL_MAX);
  assign endereco_ram = emitir ? endereco_atual : endereco_reg;
  assign dados_fila   = dados_ram;
  assign ocupado      = (estado_atual != OCIOSO);
  assign estado       = estado_atual;

`ifdef ZOOM_2X_EN
  logic zoom_reg;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) zoom_reg <= 1'b0;
    else if (estado_atual == OCIOSO && iniciar) zoom_reg <= fator_zoom;
  end
  assign zoom_efetivo = zoom_reg;
`else
  logic fator_zoom_unused;
  assign fator_zoom_unused = fator_zoom;
  assign zoom_efetivo      = 1'b0;
`endif

  gerador_endereco_zoom #(
    .LARGURA(LARGURA),
    .ALTURA (ALTURA)
  ) u_gerador (
    .ox      (ox),
    .oy      (oy),
    .zoom    (zoom_efetivo),
    .endereco(endereco_atual)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_atual     <= OCIOSO;
      ox               <= '0;
      oy               <= '0;
      endereco_reg     <= '0;
      contagem         <= '0;
      escrita_fila     <= 1'b0;
      leitura_liberada <= 1'b0;
      fim_quadro       <= 1'b0;
    end else begin
      endereco_reg <= endereco_ram;
      escrita_fila <= emitir;
      fim_quadro   <= 1'b0;
      // Sticky: the display keeps reading across frames once primed.
      if (emitir && contagem == LIMIAR_ULT) leitura_liberada <= 1'b1;
      case (estado_atual)
        OCIOSO: begin
          if (iniciar) begin
            estado_atual <= BUSCANDO;
            ox           <= '0;
            oy           <= '0;
            contagem     <= '0;
          end
        end
        BUSCANDO: begin
          if (emitir) begin
            if (contagem <= LIMIAR_ULT) contagem <= contagem + 1'b1;
            if (ox == OX_ULT) begin
              ox <= '0;
              if (oy == OY_ULT) begin
                oy           <= '0;
                estado_atual <= DRENANDO;
                fim_quadro   <= 1'b1;
              end else begin
                oy <= oy + 1'b1;
              end
            end else begin
              ox <= ox + 1'b1;
            end
          end
        end
        DRENANDO: estado_atual <= OCIOSO;
        default:  estado_atual <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_busca_pixels.sv
// Self-checking bench for controlador_busca_pixels; a per-cycle model feeds the
// expected-byte queue, scenario tasks check frame-level behaviour.
module tb_controlador_busca_pixels;

  logic        clock      = 1'b0;
  logic        reset      = 1'b0;
  logic        iniciar    = 1'b0;
  logic        fator_zoom = 1'b0;
  logic [9:0]  fila_nivel = '0;
  logic [7:0]  dados_ram  = '0;
  logic [16:0] endereco_ram;
  logic        escrita_fila;
  logic [7:0]  dados_fila;
  logic        leitura_liberada;
  logic        ocupado;
  logic        fim_quadro;
  logic [1:0]  estado;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

`ifdef ZOOM_2X_EN
  localparam bit ZOOM_ON = 1'b1;
`else
  localparam bit ZOOM_ON = 1'b0;
`endif

  controlador_busca_pixels dut (
    .clock           (clock),
    .reset           (reset),
    .iniciar         (iniciar),
    .fator_zoom      (fator_zoom),
    .fila_nivel      (fila_nivel),
    .dados_ram       (dados_ram),
    .endereco_ram    (endereco_ram),
    .escrita_fila    (escrita_fila),
    .dados_fila      (dados_fila),
    .leitura_liberada(leitura_liberada),
    .ocupado         (ocupado),
    .fim_quadro      (fim_quadro),
    .estado          (estado)
  );

  always #20 clock = ~clock;

  function automatic logic [7:0] ram_byte(input logic [16:0] a);
    return a[7:0] ^ {a[16:14], a[12:8]};
  endfunction

  function automatic logic [16:0] exp_addr(input int x, input int y, input logic z);
    int xe;
    int ye;
    xe = x;
    ye = y;
    if (z && ZOOM_ON) begin
      xe = 80 + x / 2;
      ye = 60 + y / 2;
    end
    return 17'(ye * 320 + xe);
  endfunction

  // RAM with one cycle of read latency
  always @(posedge clock) dados_ram <= ram_byte(endereco_ram);

  // Cycle model and scoreboard
  logic        m_ativo = 1'b0;
  logic        m_drena = 1'b0;
  logic        m_wr_exp = 1'b0;
  logic        m_lib = 1'b0;
  logic        m_zoom = 1'b0;
  logic        m_ocioso;
  int          m_ox = 0;
  int          m_oy = 0;
  int          m_frame_wr = 0;
  logic [16:0] m_last = '0;
  logic [16:0] mon_a;
  logic        mon_emit;
  logic [7:0]  mon_d;

  always @(negedge clock) begin
    if (reset) begin
      n_vec++;
      if (endereco_ram !== 17'd0 || escrita_fila !== 1'b0 || leitura_liberada !== 1'b0 ||
          ocupado !== 1'b0 || fim_quadro !== 1'b0) begin
        n_err++;
        $display("FAIL reset_outputs addr=%0d wr=%b lib=%b ocup=%b fim=%b required all 0",
                 endereco_ram, escrita_fila, leitura_liberada, ocupado, fim_quadro);
      end
      m_ativo = 1'b0; m_drena = 1'b0; m_wr_exp = 1'b0; m_lib = 1'b0; m_zoom = 1'b0;
      m_ox = 0; m_oy = 0; m_frame_wr = 0; m_last = '0;
      exp_q.delete();
    end else begin
      n_vec++;
      if (escrita_fila !== m_wr_exp) begin
        n_err++;
        $display("FAIL escrita_fila got %b required %b at addr %0d", escrita_fila, m_wr_exp, m_last);
      end
      if (m_wr_exp && exp_q.size() > 0) begin
        mon_d = exp_q.pop_front();
        n_vec++;
        if (dados_fila !== mon_d) begin
          n_err++;
          $display("FAIL dados_fila got %h required %h", dados_fila, mon_d);
        end
        m_frame_wr++;
        if (m_frame_wr == 480) m_lib = 1'b1;
      end
      n_vec++;
      if (leitura_liberada !== m_lib) begin
        n_err++;
        $display("FAIL leitura_liberada got %b required %b", leitura_liberada, m_lib);
      end
      n_vec++;
      if (ocupado !== (m_ativo || m_drena)) begin
        n_err++;
        $display("FAIL ocupado got %b required %b", ocupado, m_ativo || m_drena);
      end
      n_vec++;
      if (fim_quadro !== m_drena) begin
        n_err++;
        $display("FAIL fim_quadro got %b required %b", fim_quadro, m_drena);
      end
      mon_emit = m_ativo && (fila_nivel <= 10'd509);
      mon_a = mon_emit ? exp_addr(m_ox, m_oy, m_zoom) : m_last;
      n_vec++;
      if (endereco_ram !== mon_a) begin
        n_err++;
        $display("FAIL endereco_ram got %0d required %0d (ox=%0d oy=%0d)", endereco_ram, mon_a, m_ox, m_oy);
      end
      m_ocioso = !m_ativo && !m_drena;
      m_last   = mon_a;
      m_wr_exp = mon_emit;
      m_drena  = 1'b0;
      if (mon_emit) begin
        exp_q.push_back(ram_byte(mon_a));
        if (m_ox == 319) begin
          m_ox = 0;
          if (m_oy == 239) begin
            m_oy = 0; m_ativo = 1'b0; m_drena = 1'b1;
          end else begin
            m_oy++;
          end
        end else begin
          m_ox++;
        end
      end else if (m_ocioso && iniciar) begin
        m_ativo = 1'b1; m_ox = 0; m_oy = 0; m_frame_wr = 0; m_zoom = fator_zoom;
      end
    end
  end

  task automatic pulse_iniciar();
    @(posedge clock); #1 iniciar = 1'b1;
    @(posedge clock); #1 iniciar = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_vec++; if (endereco_ram !== 17'd0) begin n_err++; $display("FAIL rst_addr got %0d required 0", endereco_ram); end
    n_vec++; if (escrita_fila !== 1'b0) begin n_err++; $display("FAIL rst_wr got %b required 0", escrita_fila); end
    n_vec++; if (leitura_liberada !== 1'b0) begin n_err++; $display("FAIL rst_lib got %b required 0", leitura_liberada); end
    n_vec++; if (ocupado !== 1'b0) begin n_err++; $display("FAIL rst_ocupado got %b required 0", ocupado); end
    n_vec++; if (fim_quadro !== 1'b0) begin n_err++; $display("FAIL rst_fim got %b required 0", fim_quadro); end
    n_vec++; if (estado !== 2'd0) begin n_err++; $display("FAIL rst_estado got %0d required 0", estado); end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    n_vec++; if (escrita_fila !== 1'b0 || ocupado !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset wr=%b ocup=%b required 0 0", escrita_fila, ocupado);
    end
  endtask

  task automatic test_frame_1x();
    int   n_cyc, n_wr, n_fim, n_wr_hold;
    logic lib_prev, done;
    n_cyc = 0; n_wr = 0; n_fim = 0; n_wr_hold = 0; lib_prev = 1'b0; done = 1'b0;
    fator_zoom = 1'b0; fila_nivel = '0;
    pulse_iniciar();
    while (!done && n_cyc < 80000) begin
      @(negedge clock);
      n_cyc++;
      if (escrita_fila === 1'b1) begin
        n_wr++;
        if (n_cyc >= 5002 && n_cyc <= 5021) n_wr_hold++;
        if (n_wr == 480) begin
          n_vec++;
          if (leitura_liberada !== 1'b1 || lib_prev !== 1'b0) begin
            n_err++; $display("FAIL lib_edge now=%b before=%b required 1 0", leitura_liberada, lib_prev);
          end
        end
      end
      lib_prev = leitura_liberada;
      if (fim_quadro === 1'b1) begin
        done = 1'b1; n_fim++;
        n_vec++; if (n_cyc != 76821) begin n_err++; $display("FAIL frame_length got %0d required 76821", n_cyc); end
        n_vec++; if (endereco_ram !== 17'd76799) begin n_err++; $display("FAIL last_addr got %0d required 76799", endereco_ram); end
        n_vec++; if (estado !== 2'd2) begin n_err++; $display("FAIL drain_state got %0d required 2", estado); end
      end
      if (!done) begin
        @(posedge clock); #1;
        fila_nivel = (n_cyc >= 5000 && n_cyc < 5020) ? 10'd510 : 10'd0;
        iniciar    = (n_cyc == 3000);
      end
    end
    n_vec++; if (!done) begin n_err++; $display("FAIL frame_timeout cycles=%0d required fim_quadro", n_cyc); end
    n_vec++; if (n_wr != 76800) begin n_err++; $display("FAIL frame_writes got %0d required 76800", n_wr); end
    n_vec++; if (n_wr_hold != 0) begin n_err++; $display("FAIL hold_writes got %0d required 0", n_wr_hold); end
    repeat (4) begin
      @(negedge clock);
      if (fim_quadro === 1'b1) n_fim++;
    end
    n_vec++; if (ocupado !== 1'b0) begin n_err++; $display("FAIL ocupado_after got %b required 0", ocupado); end
    n_vec++; if (n_fim != 1) begin n_err++; $display("FAIL fim_count got %0d required 1", n_fim); end
  endtask

  task automatic test_liberada_sticky();
    fila_nivel = 10'd505;
    pulse_iniciar();
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      n_vec++;
      if (leitura_liberada !== 1'b1) begin n_err++; $display("FAIL lib_sticky got %b required 1", leitura_liberada); end
      @(posedge clock); #1 fila_nivel = 10'($urandom_range(505, 511));
    end
    @(negedge clock);
    n_vec++; if (ocupado !== 1'b1) begin n_err++; $display("FAIL ocupado_second got %b required 1", ocupado); end
  endtask

  task automatic test_reset_mid_frame();
    logic found;
    found = 1'b0;
    @(posedge clock); #1 fila_nivel = '0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clock);
      if (endereco_ram === 17'd1000) found = 1'b1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL addr1000_timeout got %0d required 1000", endereco_ram); end
    #5 reset = 1'b1;
    #1;
    n_vec++; if (endereco_ram !== 17'd0) begin n_err++; $display("FAIL abort_addr got %0d required 0", endereco_ram); end
    n_vec++; if (escrita_fila !== 1'b0) begin n_err++; $display("FAIL abort_wr got %b required 0", escrita_fila); end
    n_vec++; if (leitura_liberada !== 1'b0) begin n_err++; $display("FAIL abort_lib got %b required 0", leitura_liberada); end
    n_vec++; if (ocupado !== 1'b0) begin n_err++; $display("FAIL abort_ocupado got %b required 0", ocupado); end
    @(posedge clock);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    n_vec++; if (escrita_fila !== 1'b0) begin n_err++; $display("FAIL post_reset_write got %b required 0", escrita_fila); end
  endtask

  task automatic test_restart();
    fila_nivel = '0;
    pulse_iniciar();
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      n_vec++;
      if (endereco_ram !== 17'(i)) begin n_err++; $display("FAIL restart_addr got %0d required %0d", endereco_ram, i); end
      @(posedge clock); #1 iniciar = (i == 5);
    end
    apply_reset();
  endtask

`ifdef ZOOM_2X_EN
  task automatic test_zoom();
    logic [16:0] esperado [4];
    esperado = '{17'd19280, 17'd19280, 17'd19281, 17'd19281};
    fila_nivel = '0;
    fator_zoom = 1'b1;
    pulse_iniciar();
    fator_zoom = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clock);
      if (i < 4) begin
        n_vec++;
        if (endereco_ram !== esperado[i]) begin n_err++; $display("FAIL zoom_start[%0d] got %0d required %0d", i, endereco_ram, esperado[i]); end
      end
      if (i == 640) begin
        n_vec++;
        if (endereco_ram !== 17'd19600) begin n_err++; $display("FAIL zoom_line2 got %0d required 19600", endereco_ram); end
      end
      @(posedge clock); #1 fator_zoom = 1'($urandom_range(0, 1));
    end
    apply_reset();
  endtask
`else
  task automatic test_zoom_ignored();
    fila_nivel = '0;
    fator_zoom = 1'b1;
    pulse_iniciar();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      n_vec++;
      if (endereco_ram !== 17'(i)) begin n_err++; $display("FAIL zoom_ignored got %0d required %0d", endereco_ram, i); end
    end
    fator_zoom = 1'b0;
    apply_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_frame_1x();
    test_liberada_sticky();
    test_reset_mid_frame();
    test_restart();
`ifdef ZOOM_2X_EN
    test_zoom();
`else
    test_zoom_ignored();
`endif
    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
